ram_burst_ctrl: RTL and testbench

- Initiator-side controller for the multiplier's single-clock RAM (16-bit words, 128 entries, registered read address, write/address update gated by an enable).
- Accepts burst commands, then either streams write data into the RAM or streams read data out of it.
- Drives the RAM's address, data, write, and enable pins, and absorbs the RAM's one-cycle read latency.
- Supports read back-pressure by holding the RAM's registered address.

---
 rtl/ram_burst_ctrl.sv | 149 ++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a single-clock RAM with a registered read address.
// Streams write words into the RAM or read words out of it, with read back-pressure.
module ram_burst_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_d;
    logic [ADDR_WIDTH-1:0] len, len_d;
    logic [ADDR_WIDTH-1:0] count, count_d;
    logic                  rd_valid_d;
    logic                  rd_last_d;
    logic                  done_d;
    logic                  beat;
    logic                  issue;

    // The RAM's registered address drives q, so read data is a straight passthrough.
    assign rd_data = ram_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cur_addr <= '0;
            len      <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            cur_addr <= cur_addr_d;
            len      <= len_d;
            count    <= count_d;
            rd_valid <= rd_valid_d;
            rd_last  <= rd_last_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d          = state;
        cur_addr_d       = cur_addr;
        len_d            = len;
        count_d          = count;
        rd_valid_d       = rd_valid;
        rd_last_d        = rd_last;
        done_d           = 1'b0;
        cmd_ready        = 1'b0;
        wr_ready         = 1'b0;
        ram_we           = 1'b0;
        ram_write_enable = 1'b0;
        ram_addr         = cur_addr;
        ram_data         = wr_data;
        beat             = 1'b0;
        issue            = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_d = cmd_base;
                    len_d      = cmd_len;
                    count_d    = '0;
                    state_d    = cmd_write ? WRITE : READ;
                end
            end

            WRITE: begin
                wr_ready = 1'b1;
                beat     = wr_valid;
                if (beat) begin
                    ram_we           = 1'b1;
                    ram_write_enable = 1'b1;
                    cur_addr_d       = cur_addr + ADDR_WIDTH'(1);
                    count_d          = count + ADDR_WIDTH'(1);
                    if (count == len) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            READ: begin
                // Withholding write_enable during a stall freezes the RAM address register.
                issue = !rd_valid || rd_ready;
                if (issue) begin
                    ram_write_enable = 1'b1;
                    cur_addr_d       = cur_addr + ADDR_WIDTH'(1);
                    count_d          = count + ADDR_WIDTH'(1);
                    rd_valid_d       = 1'b1;
                    rd_last_d        = (count == len);
                    if (count == len) begin
                        state_d = DRAIN;
                    end
                end else if (rd_ready) begin
                    rd_valid_d = 1'b0;
                end
            end

            DRAIN: begin
                if (rd_valid && rd_ready && rd_last) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Never touch the RAM while reset is held.
        if (reset) begin
            ram_we           = 1'b0;
            ram_write_enable = 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl: external RAM model plus a shadow-memory
// reference that predicts every write address and every read word in burst order.
module tb_ram_burst_ctrl;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 7;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned BUDGET = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_base, cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_last, done;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_we, ram_write_enable;

    logic [DW-1:0] mem     [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] wdata   [0:DEPTH-1];
    logic [AW-1:0] ram_areg = '0;

    int errors = 0;
    int checks = 0;
    bit done_due = 1'b0;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .done(done),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_write_enable(ram_write_enable), .ram_q(ram_q)
    );

    // External RAM: write and address register both gated by write_enable.
    always @(posedge clk) begin
        if (ram_write_enable) begin
            if (ram_we) mem[ram_addr] <= ram_data;
            ram_areg <= ram_addr;
        end
    end
    assign ram_q = mem[ram_areg];

    function automatic logic [AW-1:0] wrap_addr(input int unsigned base, input int unsigned i);
        return AW'((base + i) % DEPTH);
    endfunction

    task automatic send_cmd(input logic wr, input int unsigned base, input int unsigned len);
        cmd_valid = 1'b1; cmd_write = wr; cmd_base = AW'(base); cmd_len = AW'(len);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (done !== done_due) begin errors++; $display("FAIL done_at_cmd: got %b expected %b", done, done_due); end
        done_due = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (done !== done_due) begin errors++; $display("FAIL idle_done: got %b expected %b", done, done_due); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL idle_rd_valid: got %b expected 0", rd_valid); end
        done_due = 1'b0;
        @(posedge clk); #1;
    endtask

    // mode 0: wr_valid always high, 1: pattern 1,0,0,1,1 repeating, 2: random
    task automatic do_write(input int unsigned base, input int unsigned len, input int mode);
        int  beats = 0;
        int  cyc = 0;
        bit  fin = 1'b0;
        bit  v;
        bit  pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        while (!fin && cyc < BUDGET) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 5] : 1'($urandom_range(0, 1));
            wr_valid = v;
            wr_data  = wdata[beats];
            @(negedge clk);
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", wr_ready); end
            checks++; if (ram_we !== v) begin errors++; $display("FAIL wr_ram_we: cyc %0d got %b expected %b", cyc, ram_we, v); end
            checks++; if (ram_write_enable !== v) begin errors++; $display("FAIL wr_ram_wen: cyc %0d got %b expected %b", cyc, ram_write_enable, v); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_early: got %b expected 0", done); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_cmd_ready: got %b expected 0", cmd_ready); end
            checks++; if (ram_data !== wr_data) begin errors++; $display("FAIL wr_ram_data: got %h expected %h", ram_data, wr_data); end
            if (v) begin
                checks++;
                if (ram_addr !== wrap_addr(base, beats)) begin
                    errors++; $display("FAIL wr_ram_addr: beat %0d got %0d expected %0d", beats, ram_addr, wrap_addr(base, beats));
                end
                ref_mem[wrap_addr(base, beats)] = wdata[beats];
                beats++;
                if (beats == int'(len) + 1) fin = 1'b1;
            end
            cyc++;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        if (!fin) begin errors++; $display("FAIL wr_timeout: got %0d beats expected %0d", beats, len + 1); end
        done_due = fin;
    endtask

    // mode 0: rd_ready always high, 1: stall 3 cycles on 2nd word, 2: random
    task automatic do_read(input int unsigned base, input int unsigned len, input int mode, input int abort_after);
        int k = 0;
        int issued = 0;
        int cyc = 0;
        int stall = 0;
        bit fin = 1'b0;
        logic [DW-1:0] exp;
        while (!fin && cyc < BUDGET) begin
            cyc++;
            if (mode == 1) begin
                rd_ready = !(rd_valid && k == 1 && stall < 3);
                if (!rd_ready) stall++;
            end else if (mode == 2) begin
                rd_ready = ($urandom_range(0, 3) != 0);
            end else begin
                rd_ready = 1'b1;
            end
            @(negedge clk);
            checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rd_ram_we: got %b expected 0", ram_we); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rd_done_early: got %b expected 0", done); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd_cmd_ready: got %b expected 0", cmd_ready); end
            if (mode == 0) begin
                checks++;
                if (rd_valid !== (cyc >= 2)) begin errors++; $display("FAIL rd_valid_timing: cyc %0d got %b expected %b", cyc, rd_valid, cyc >= 2); end
            end
            if (ram_write_enable === 1'b1) begin
                checks++;
                if (issued > int'(len) || ram_addr !== wrap_addr(base, issued)) begin
                    errors++; $display("FAIL rd_issue_addr: issue %0d got %0d expected %0d", issued, ram_addr, wrap_addr(base, issued));
                end
                issued++;
            end
            if (rd_valid === 1'b1) begin
                exp = ref_mem[wrap_addr(base, k)];
                checks++; if (rd_data !== exp) begin errors++; $display("FAIL rd_data: word %0d got %h expected %h", k, rd_data, exp); end
                checks++; if (rd_last !== (k == int'(len))) begin errors++; $display("FAIL rd_last: word %0d got %b expected %b", k, rd_last, k == int'(len)); end
                if (!rd_ready) begin
                    checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL rd_stall_wen: got %b expected 0", ram_write_enable); end
                end else begin
                    k++;
                    if (k == int'(len) + 1) fin = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (k == abort_after) begin
                reset = 1'b1;
                @(negedge clk);
                checks++; if (ram_write_enable !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_gate: got %b%b expected 00", ram_write_enable, ram_we); end
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL abort_rd_valid: got %b expected 0", rd_valid); end
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_cmd_ready: got %b expected 1", cmd_ready); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", done); end
                @(posedge clk); #1;
                done_due = 1'b0;
                return;
            end
        end
        rd_ready = 1'b0;
        if (!fin) begin errors++; $display("FAIL rd_timeout: got %0d words expected %0d", k, len + 1); end
        done_due = fin;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; wr_valid = 1'b1; rd_ready = 1'b0;
        cmd_base = '0; cmd_len = '0; wr_data = '0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (ram_we !== 1'b0 || ram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_ram_ctrl: got %b%b expected 00", ram_we, ram_write_enable); end
        end
        @(posedge clk); #1;
        reset = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b expected 0", rd_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read_basic();
        wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333; wdata[3] = 16'h4444;
        send_cmd(1'b1, 5, 3); do_write(5, 3, 0);
        send_cmd(1'b0, 5, 3); do_read(5, 3, 0, -1);
        idle_cycle();
        send_cmd(1'b0, 5, 3); do_read(5, 3, 1, -1);
        idle_cycle();
    endtask

    task automatic test_wrap();
        logic [DW-1:0] a;
        wdata[0] = 16'hAAAA; wdata[1] = 16'hBBBB; wdata[2] = 16'hCCCC;
        send_cmd(1'b1, 126, 2); do_write(126, 2, 0);
        idle_cycle();
        a = mem[126]; checks++; if (a !== 16'hAAAA) begin errors++; $display("FAIL wrap_mem126: got %h expected aaaa", a); end
        a = mem[127]; checks++; if (a !== 16'hBBBB) begin errors++; $display("FAIL wrap_mem127: got %h expected bbbb", a); end
        a = mem[0];   checks++; if (a !== 16'hCCCC) begin errors++; $display("FAIL wrap_mem0: got %h expected cccc", a); end
        send_cmd(1'b0, 126, 2); do_read(126, 2, 0, -1);
        idle_cycle();
    endtask

    task automatic test_write_gaps();
        for (int i = 0; i < 3; i++) wdata[i] = DW'($urandom);
        send_cmd(1'b1, 40, 2); do_write(40, 2, 1);
        send_cmd(1'b0, 40, 2); do_read(40, 2, 2, -1);
        idle_cycle();
    endtask

    task automatic test_reset_mid_read();
        send_cmd(1'b0, 5, 3); do_read(5, 3, 0, 2);
        idle_cycle();
        send_cmd(1'b0, 5, 0); do_read(5, 0, 0, -1);
        idle_cycle();
    endtask

    task automatic test_full_sweep();
        for (int i = 0; i < int'(DEPTH); i++) wdata[i] = DW'($urandom);
        send_cmd(1'b1, 0, 127); do_write(0, 127, 2);
        send_cmd(1'b0, 64, 127); do_read(64, 127, 2, -1);
        idle_cycle();
    endtask

    task automatic test_back_to_back_random();
        int unsigned b, l;
        for (int n = 0; n < 6; n++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 20);
            for (int i = 0; i <= int'(l); i++) wdata[i] = DW'($urandom);
            send_cmd(1'b1, b, l); do_write(b, l, 2);
            send_cmd(1'b0, b, l); do_read(b, l, (n % 2 == 0) ? 0 : 2, -1);
        end
        idle_cycle();
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write_read_basic();
        test_wrap();
        test_write_gaps();
        test_reset_mid_read();
        test_full_sweep();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
